// File: rtl/ivector_serializer_pkg.sv
// Shared widths, FSM states and header beat layout for the 704-bit to 32-bit echo-path serializer.
// HEADER state exists only when IVECTOR_SER_HEADER_EN is defined.
package ivector_pkg;

  localparam int IVECTOR_WIDTH = 704;
  localparam int IVECTOR_BEAT  = 32;
  localparam int IVECTOR_BEATS = IVECTOR_WIDTH / IVECTOR_BEAT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef IVECTOR_SER_HEADER_EN
    HEADER = 2'd1,
`endif
    SEND   = 2'd2
  } ivser_state_t;

  typedef struct packed {
    logic [15:0] seq;
    logic [7:0]  rsvd;
    logic [7:0]  beats;
  } ivser_header_t;

endpackage

// File: rtl/ivector_serializer_if.sv
// Message-in / beat-out handshake bundle; slave is the serializer, master is the surrounding logic.
interface ivector_serializer_if #(
  parameter int WIDTH = ivector_pkg::IVECTOR_WIDTH,
  parameter int BEAT  = ivector_pkg::IVECTOR_BEAT
) ();

  logic             heard_ena;
  logic [WIDTH-1:0] heard_v;
  logic             heard_rdy;
  logic             beat_ena;
  logic [BEAT-1:0]  beat_v;
  logic             beat_last;
  logic             beat_rdy;

  modport master (
    output heard_ena, heard_v, beat_rdy,
    input  heard_rdy, beat_ena, beat_v, beat_last
  );

  modport slave (
    input  heard_ena, heard_v, beat_rdy,
    output heard_rdy, beat_ena, beat_v, beat_last
  );

endinterface

// File: rtl/ivector_serializer.sv
// Drains one WIDTH-bit message as BEAT-bit words LSW first; first beat one cycle after accept, zero-bubble reload.
// beat_rdy low stalls with payload held; IVECTOR_SER_HEADER_EN prepends a {seq, 0, BEATS} header beat.
module ivector_serializer
  import ivector_pkg::*;
#(
  parameter int WIDTH = IVECTOR_WIDTH,
  parameter int BEAT  = IVECTOR_BEAT
) (
  input logic                  clk,
  input logic                  rst,
  ivector_serializer_if.slave  port
);

  localparam int BEATS = WIDTH / BEAT;
  localparam int IDX_W = $clog2(BEATS + 1);

`ifdef IVECTOR_SER_HEADER_EN
  localparam ivser_state_t FIRST = HEADER;
`else
  localparam ivser_state_t FIRST = SEND;
`endif

  ivser_state_t     state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [IDX_W-1:0] idx;
  logic             load, shift, last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sreg <= port.heard_v;
        idx  <= '0;
      end else if (shift) begin
        sreg <= sreg >> BEAT;
        idx  <= idx + IDX_W'(1);
      end
    end
  end

`ifdef IVECTOR_SER_HEADER_EN
  logic [15:0]   seq;
  logic          hdr_take;
  ivser_header_t hdr;

  assign hdr = '{seq: seq, rsvd: 8'd0, beats: 8'(BEATS)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           seq <= 16'd0;
    else if (hdr_take) seq <= seq + 16'd1;
  end
`endif

  assign last_beat = (state == SEND) && (idx == IDX_W'(BEATS - 1));

  always_comb begin
    state_nxt      = state;
    load           = 1'b0;
    shift          = 1'b0;
    port.heard_rdy = 1'b0;
    port.beat_ena  = 1'b0;
    port.beat_last = 1'b0;
    port.beat_v    = sreg[BEAT-1:0];
`ifdef IVECTOR_SER_HEADER_EN
    hdr_take       = 1'b0;
`endif
    case (state)
      IDLE: begin
        port.heard_rdy = 1'b1;
        if (port.heard_ena) begin
          load      = 1'b1;
          state_nxt = FIRST;
        end
      end
`ifdef IVECTOR_SER_HEADER_EN
      HEADER: begin
        port.beat_v   = hdr;
        port.beat_ena = port.beat_rdy;
        if (port.beat_rdy) begin
          hdr_take  = 1'b1;
          state_nxt = SEND;
        end
      end
`endif
      SEND: begin
        port.beat_last = last_beat;
        port.beat_ena  = port.beat_rdy;
        if (port.beat_rdy) begin
          shift = 1'b1;
          // Last word leaving frees the register for an overlapping load.
          if (last_beat) begin
            port.heard_rdy = 1'b1;
            if (port.heard_ena) begin
              load      = 1'b1;
              state_nxt = FIRST;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      port.beat_ena  = 1'b0;
      port.beat_last = 1'b0;
    end
  end

endmodule

// File: doc/ivector_serializer.md
# ivector_serializer

Downstream width converter for the echo path: consumes the 704-bit `heard` indication produced by the vector echo stage and emits it as a stream of 32-bit beats toward the host portal. Holds one message in a shift register, drains it least-significant word first under a ready/enable handshake, and marks the final beat. Accepts the next message on the same cycle its last beat is taken, giving zero-bubble throughput.

## Interface
- `WIDTH`, 704, message width in bits; must be an integer multiple of `BEAT`.
- `BEAT`, 32, output beat width in bits.
- `CLK`  input  1  clock; all state updates on rising edge.
- `RST`  input  1  reset, asynchronous, active-high.
- `heard__ENA`  input  1  upstream delivers a message; legal only while `heard__RDY`=1.
- `heard$v`  input  WIDTH  message payload, sampled when `heard__ENA`=1.
- `heard__RDY`  output  1  serializer can accept a message this cycle.
- `beat__ENA`  output  1  beat presented and taken this cycle.
- `beat$v`  output  BEAT  beat payload.
- `beat$last`  output  1  final beat of the current message.
- `beat__RDY`  input  1  downstream can take a beat this cycle.

## Operation
- Derived: `BEATS` = WIDTH/BEAT (22); beat index counter width = $clog2(BEATS+1).
- States: IDLE, HEADER (only with `IVECTOR_SER_HEADER_EN`), SEND.
- IDLE: `heard__RDY`=1. On `heard__ENA`: load shift register with `heard$v`, index←0, go to HEADER if enabled else SEND.
- HEADER: `beat$v` = header word; `beat$last`=0. When `beat__RDY`: go to SEND.
- SEND: `beat$v` = shift register [BEAT-1:0]; `beat$last` = (index==BEATS-1). When `beat__RDY`: shift right by BEAT, index+1.
- Last beat taken (SEND, index==BEATS-1, `beat__RDY`=1): `heard__RDY`=1 this cycle; if `heard__ENA` also 1, load new message and restart (HEADER or SEND) with no idle cycle; else go to IDLE.
- `beat__ENA` = `beat__RDY` && (state is HEADER or SEND); combinational from `beat__RDY`.
- `heard__RDY` = (state==IDLE) || (last beat being taken); combinational from `beat__RDY`.
- `heard__ENA` asserted while `heard__RDY`=0 is a protocol error; ignored, no state change.
- Reset (any time, including mid-message): state←IDLE, index←0, shift register←0, sequence←0; in-flight message discarded, never resumed. While `RST`=1: `beat__ENA`=0, `beat$last`=0, `heard__ENA` ignored.

## Timing
- Message accepted at edge t → first beat (header or word 0) presentable from cycle t+1.
- With `beat__RDY` held high: BEATS cycles per message (BEATS+1 with header), back-to-back.
- `beat__RDY` low stalls; `beat$v`/`beat$last` held stable until taken.
- Word order: beat k carries `heard$v`[k*BEAT +: BEAT], k=0..BEATS-1.

## Configuration
- `IVECTOR_SER_HEADER_EN` defined: each message preceded by one header beat: [7:0]=BEATS, [15:8]=0, [31:16]=16-bit sequence number; sequence increments (mod 65536) when the header beat is taken, reset value 0.
- Undefined: no HEADER state, no sequence register; first beat is word 0.

## Structure
- Package `ivector_pkg`: `IVECTOR_WIDTH`=704, `IVECTOR_BEAT`=32, `IVECTOR_BEATS`=22, state enum `ivser_state_t`, packed header struct `ivser_header_t` (seq[15:0], rsvd[7:0], beats[7:0]).
- Single module; no sub-module warranted (one shift register, one counter, one FSM).

## Test plan
- Single message, word k = 32'h1000_0000+k, `beat__RDY`=1 → 22 beats, beat k = 32'h1000_0000+k, `beat$last` only on beat 21, `heard__RDY` high again on beat-21 cycle.
- Two messages back-to-back, second `heard__ENA` on first's last-beat cycle → 44 consecutive beats, no gap.
- `beat__RDY` toggling 1,0,0,1 pattern → payload held stable while low, all 22 beats correct and in order.
- `RST` asserted asynchronously after beat 10 → `beat__ENA` drops immediately; next message starts at word 0, sequence 0.
- Header enabled, three messages → header beats 32'h0000_0016, 32'h0001_0016, 32'h0002_0016, each followed by 22 data beats.
- `heard__ENA` pulsed mid-drain (`heard__RDY`=0) → ignored, current message output unchanged.
